// File: rtl/cas_scheduler_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cas_scheduler_pkg
//  Purpose  : Shared types and turnaround helpers for the CAS scheduler.
//  Revision : 1.0 - initial release
// ============================================================================
package cas_scheduler_pkg;

  // Direction of a column access.
  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } rw_t;

  // Scheduler FSM states.
  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    WAIT_TRCD = 3'd1,
    WAIT_TURN = 3'd2,
    WAIT_DATA = 3'd3,
    WAIT_WTR  = 3'd4,
    ISSUE     = 3'd5
  } cas_sched_state_t;

  // Minimum CAS-to-CAS spacing for a READ followed by a WRITE.
  function automatic int rtw_gap(input int tccd, input int cl, input int cwl, input int bl);
    int g;
    g = cl - cwl + bl / 2 + 2;
    return (g > tccd) ? g : tccd;
  endfunction

  // Cycles from the last write burst completing to the next READ CAS.
  function automatic int wtr_count(input int t_wtr);
    return t_wtr + 4;
  endfunction

endpackage
`default_nettype wire

// File: rtl/cas_scheduler_act_queue.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cas_scheduler_act_queue
//  Purpose  : Circular FIFO of activated accesses with per-entry tRCD ages.
//  Revision : 1.0 - initial release
// ============================================================================
module cas_scheduler_act_queue
  import cas_scheduler_pkg::*;
#(
  parameter int DEPTH  = 8,
  parameter int BANK_W = 4,
  parameter int T_RCD  = 15
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     i_push,
  input  rw_t                      i_push_rw,
  input  logic [BANK_W-1:0]        i_push_bank,
  input  logic                     i_pop,
  input  logic                     i_flush,
  output logic                     o_head_valid,
  output rw_t                      o_head_rw,
  output logic [BANK_W-1:0]        o_head_bank,
  output logic                     o_head_rcd_ok,
  output logic [$clog2(DEPTH):0]   o_count
);

  localparam int AGE_W = $clog2(T_RCD + 1);
  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [AGE_W-1:0] AGE_MAX = AGE_W'(T_RCD);

  logic [DEPTH-1:0]  r_vld;
  rw_t               r_rw   [DEPTH];
  logic [BANK_W-1:0] r_bank [DEPTH];
  logic [AGE_W-1:0]  r_age  [DEPTH];
  logic [PTR_W-1:0]  r_head;
  logic [PTR_W-1:0]  r_tail;
  logic [PTR_W:0]    r_count;

  // Pointers, occupancy and entry-valid bits; flush empties the queue.
  always_ff @(posedge clk) begin
    if (rst || i_flush) begin
      r_vld   <= '0;
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= '0;
    end else begin
      if (i_pop) begin
        r_vld[r_head] <= 1'b0;
        r_head        <= r_head + 1'b1;
      end
      if (i_push) begin
        r_vld[r_tail] <= 1'b1;
        r_tail        <= r_tail + 1'b1;
      end
      case ({i_push, i_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Entry payload; validity is tracked separately so no reset is needed.
  always_ff @(posedge clk) begin
    if (i_push) begin
      r_rw[r_tail]   <= i_push_rw;
      r_bank[r_tail] <= i_push_bank;
    end
  end

  // Age every live entry each cycle, saturating at tRCD; new entries start at zero.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (i_push && (r_tail == PTR_W'(i))) begin
        r_age[i] <= '0;
      end else if (r_vld[i] && (r_age[i] != AGE_MAX)) begin
        r_age[i] <= r_age[i] + 1'b1;
      end
    end
  end

  assign o_head_valid  = (r_count != '0);
  assign o_head_rw     = r_rw[r_head];
  assign o_head_bank   = r_bank[r_head];
  // The head reaches tRCD at the coming edge, which is when a registered CAS would appear.
  assign o_head_rcd_ok = (int'(r_age[r_head]) >= (T_RCD - 1));
  assign o_count       = r_count;

endmodule
`default_nettype wire

// File: rtl/cas_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : cas_scheduler
//  Purpose  : Queue-backed multi-bank CAS scheduler honouring tRCD, tCCD,
//             read-to-write and write-to-read turnaround.
//  Revision : 1.0 - initial release
// ============================================================================
module cas_scheduler
  import cas_scheduler_pkg::*;
#(
  parameter int NUM_BANKS   = 16,
  parameter int QUEUE_DEPTH = 8,
  parameter int T_RCD       = 15,
  parameter int T_WTR       = 6,
  parameter int CNT_W       = 8
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          i_act_valid,
  output logic                          o_act_ready,
  input  rw_t                           i_act_rw,
  input  logic [$clog2(NUM_BANKS)-1:0]  i_act_bank,
  input  logic                          i_flush,
  input  logic                          i_rw_done,
  input  logic [CNT_W-1:0]              i_tccd,
  input  logic [CNT_W-1:0]              i_cl,
  input  logic [CNT_W-1:0]              i_cwl,
  input  logic [CNT_W-1:0]              i_bl,
  output logic                          o_cas_valid,
  input  logic                          i_cas_ready,
  output rw_t                           o_cas_rw,
  output logic [$clog2(NUM_BANKS)-1:0]  o_cas_bank,
  output logic                          o_cas_idle,
  output logic [$clog2(QUEUE_DEPTH):0]  o_q_count
);

  localparam int BANK_W = $clog2(NUM_BANKS);
  localparam int QCNT_W = $clog2(QUEUE_DEPTH) + 1;

  cas_sched_state_t  r_state;
  cas_sched_state_t  w_state_nxt;
  logic              r_act_ready;
  logic              r_cas_valid;
  logic              r_cas_idle;
  rw_t               r_cas_rw;
  logic [BANK_W-1:0] r_cas_bank;
  rw_t               r_prev_rw;
  logic [CNT_W-1:0]  r_gap;
  logic [CNT_W-1:0]  r_wtr_cnt;
  logic              r_wtr_done;

  logic              w_push;
  logic              w_pop;
  logic              w_head_valid;
  logic              w_head_rcd_ok;
  rw_t               w_head_rw;
  logic [BANK_W-1:0] w_head_bank;
  logic [QCNT_W-1:0] w_count;
  logic [QCNT_W-1:0] w_count_nxt;
  int                w_need;
  logic              w_gap_ok;
  logic              w_wtr_ok;

  assign w_push = i_act_valid & r_act_ready & ~i_flush;
  assign w_pop  = r_cas_valid & i_cas_ready;

  cas_scheduler_act_queue #(
    .DEPTH  (QUEUE_DEPTH),
    .BANK_W (BANK_W),
    .T_RCD  (T_RCD)
  ) u_queue (
    .clk           (clk),
    .rst           (rst),
    .i_push        (w_push),
    .i_push_rw     (i_act_rw),
    .i_push_bank   (i_act_bank),
    .i_pop         (w_pop),
    .i_flush       (i_flush),
    .o_head_valid  (w_head_valid),
    .o_head_rw     (w_head_rw),
    .o_head_bank   (w_head_bank),
    .o_head_rcd_ok (w_head_rcd_ok),
    .o_count       (w_count)
  );

  // Occupancy after the coming edge, used for the registered ready/idle flags.
  always_comb begin
    w_count_nxt = w_count;
    if (i_flush) begin
      w_count_nxt = '0;
    end else if (w_push && !w_pop) begin
      w_count_nxt = w_count + 1'b1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = w_count - 1'b1;
    end
  end

  // Turnaround checks; the +2 accounts for the registered CAS landing one cycle
  // after the decision and the counters starting at zero one cycle after the event.
  always_comb begin
    w_need = int'(i_tccd);
    if ((r_prev_rw == READ) && (w_head_rw == WRITE)) begin
      w_need = rtw_gap(int'(i_tccd), int'(i_cl), int'(i_cwl), int'(i_bl));
    end
    w_gap_ok = ((int'(r_gap) + 2) >= w_need);
    w_wtr_ok = ((int'(r_wtr_cnt) + 2) >= wtr_count(T_WTR));
  end

  // Next-state selection; flush always returns to IDLE.
  always_comb begin
    w_state_nxt = r_state;
    if (r_state == ISSUE) begin
      if (w_pop) begin
        w_state_nxt = (w_count_nxt != '0) ? WAIT_TRCD : IDLE;
      end
    end else if (!w_head_valid) begin
      w_state_nxt = IDLE;
    end else if (!w_head_rcd_ok) begin
      w_state_nxt = WAIT_TRCD;
    end else if ((r_prev_rw == WRITE) && (w_head_rw == READ)) begin
      if (!r_wtr_done) begin
        w_state_nxt = WAIT_DATA;
      end else if (!w_wtr_ok || !w_gap_ok) begin
        w_state_nxt = WAIT_WTR;
      end else begin
        w_state_nxt = ISSUE;
      end
    end else if (!w_gap_ok) begin
      w_state_nxt = WAIT_TURN;
    end else begin
      w_state_nxt = ISSUE;
    end
    if (i_flush) begin
      w_state_nxt = IDLE;
    end
  end

  // State register and registered command/status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cas_valid <= 1'b0;
      r_cas_rw    <= READ;
      r_cas_bank  <= '0;
      r_cas_idle  <= 1'b1;
      r_act_ready <= 1'b1;
    end else begin
      r_state     <= w_state_nxt;
      r_cas_valid <= (w_state_nxt == ISSUE);
      // Capture the command once on entry so it stays stable until accepted.
      if ((r_state != ISSUE) && (w_state_nxt == ISSUE)) begin
        r_cas_rw   <= w_head_rw;
        r_cas_bank <= w_head_bank;
      end
      r_cas_idle  <= (w_state_nxt == IDLE) && (w_count_nxt == '0);
      r_act_ready <= (int'(w_count_nxt) < QUEUE_DEPTH);
    end
  end

  // Turnaround history: last direction, CAS gap and write-to-read tracking.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_prev_rw  <= READ;
      r_gap      <= '1;
      r_wtr_done <= 1'b0;
      r_wtr_cnt  <= '1;
    end else begin
      if (w_pop) begin
        r_prev_rw <= r_cas_rw;
        r_gap     <= '0;
      end else if (r_gap != '1) begin
        r_gap <= r_gap + 1'b1;
      end
      // A write CAS invalidates any earlier burst-done indication.
      if (w_pop && (r_cas_rw == WRITE)) begin
        r_wtr_done <= 1'b0;
        r_wtr_cnt  <= '1;
      end else if (i_rw_done) begin
        r_wtr_done <= 1'b1;
        r_wtr_cnt  <= '0;
      end else if (r_wtr_cnt != '1) begin
        r_wtr_cnt <= r_wtr_cnt + 1'b1;
      end
    end
  end

  assign o_act_ready = r_act_ready;
  assign o_cas_valid = r_cas_valid;
  assign o_cas_rw    = r_cas_rw;
  assign o_cas_bank  = r_cas_bank;
  assign o_cas_idle  = r_cas_idle;
  assign o_q_count   = w_count;

endmodule
`default_nettype wire

// File: tb/tb_cas_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module   : tb_cas_scheduler
//  Purpose  : Directed self-checking bench for cas_scheduler with a CAS
//             scoreboard (direction, bank and handshake cycle).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_cas_scheduler;
  import cas_scheduler_pkg::*;

  localparam int T_RCD = 4;
  localparam int T_WTR = 6;

  typedef struct {
    rw_t        rw;
    logic [3:0] bank;
    int         cyc;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       act_valid;
  logic       act_ready;
  rw_t        act_rw;
  logic [3:0] act_bank;
  logic       flush;
  logic       rw_done;
  logic [7:0] tccd;
  logic [7:0] cl;
  logic [7:0] cwl;
  logic [7:0] bl;
  logic       cas_valid;
  logic       cas_ready;
  rw_t        cas_rw;
  logic [3:0] cas_bank;
  logic       cas_idle;
  logic [3:0] q_count;

  int   cyc = 0;
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];

  cas_scheduler #(
    .NUM_BANKS   (16),
    .QUEUE_DEPTH (8),
    .T_RCD       (T_RCD),
    .T_WTR       (T_WTR),
    .CNT_W       (8)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .i_act_valid (act_valid),
    .o_act_ready (act_ready),
    .i_act_rw    (act_rw),
    .i_act_bank  (act_bank),
    .i_flush     (flush),
    .i_rw_done   (rw_done),
    .i_tccd      (tccd),
    .i_cl        (cl),
    .i_cwl       (cwl),
    .i_bl        (bl),
    .o_cas_valid (cas_valid),
    .i_cas_ready (cas_ready),
    .o_cas_rw    (cas_rw),
    .o_cas_bank  (cas_bank),
    .o_cas_idle  (cas_idle),
    .o_q_count   (q_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Cycle number: cycle k is the interval following the k-th rising edge.
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) step();
  endtask

  task automatic goto_neg(input int c);
    while (cyc < c) step();
    @(negedge clk);
  endtask

  // One-cycle ACT; when a CAS is expected its handshake cycle is queued.
  task automatic act(input rw_t rw, input int bank, input int exp_cyc, input bit expect_cas);
    exp_t e;
    act_valid = 1'b1;
    act_rw    = rw;
    act_bank  = bank[3:0];
    if (expect_cas) begin
      e.rw   = rw;
      e.bank = bank[3:0];
      e.cyc  = exp_cyc;
      sb.push_back(e);
    end
    step();
    act_valid = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest expected CAS.
  always @(negedge clk) begin
    exp_t e;
    if (cas_valid && cas_ready) begin
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_cas: observed bank %0d at cycle %0d, expected no CAS", cas_bank, cyc);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("cas_rw", cas_rw, e.rw);
        check("cas_bank", cas_bank, e.bank);
        check("cas_cycle", cyc, e.cyc);
      end
    end
  end

  initial begin
    int n;
    int r;
    rst       = 1'b1;
    act_valid = 1'b0;
    act_rw    = READ;
    act_bank  = '0;
    flush     = 1'b0;
    rw_done   = 1'b0;
    tccd      = 8'd4;
    cl        = 8'd11;
    cwl       = 8'd9;
    bl        = 8'd8;
    cas_ready = 1'b1;
    repeat (3) step();

    // Reset values
    @(negedge clk);
    check("rst_act_ready", act_ready, 1);
    check("rst_cas_valid", cas_valid, 0);
    check("rst_cas_rw", cas_rw, READ);
    check("rst_cas_bank", cas_bank, 0);
    check("rst_cas_idle", cas_idle, 1);
    check("rst_q_count", q_count, 0);
    step();
    rst = 1'b0;
    repeat (3) step();

    // Single READ: CAS at ACT+T_RCD, idle the cycle after
    n = cyc + 1;
    act(READ, 3, n + T_RCD, 1'b1);
    goto_neg(n + T_RCD - 1);
    check("single_not_early", cas_valid, 0);
    goto_neg(n + T_RCD + 1);
    check("single_idle_after", cas_idle, 1);
    goto(n + 12);

    // Four READs back to back, tCCD spacing
    n = cyc + 1;
    for (int k = 0; k < 4; k++) act(READ, 4 + k, n + 4 + 4 * k, 1'b1);
    goto(n + 24);

    // READ then WRITE: read-to-write gap of 8
    n = cyc + 1;
    act(READ, 7, n + 4, 1'b1);
    act(WRITE, 8, n + 12, 1'b1);
    goto(n + 20);

    // WRITE then READ: read issues T_WTR+4 after rw_done
    n = cyc + 1;
    act(WRITE, 9, n + 4, 1'b1);
    act(READ, 10, n + 24, 1'b1);
    goto(n + 14);
    rw_done = 1'b1;
    step();
    rw_done = 1'b0;
    goto(n + 32);

    // Fill the queue with the encoder stalled, then release
    cas_ready = 1'b0;
    n = cyc + 1;
    r = n + 12;
    for (int k = 0; k < 8; k++) act(READ, k, r + 4 * k, 1'b1);
    act(READ, 9, 0, 1'b0);
    goto_neg(n + 8);
    check("full_q_count", q_count, 8);
    check("full_act_ready", act_ready, 0);
    check("full_cas_held", cas_valid, 1);
    check("full_cas_bank", cas_bank, 0);
    goto(r);
    cas_ready = 1'b1;
    goto_neg(r + 1);
    check("drain_act_ready", act_ready, 1);
    check("drain_q_count", q_count, 7);
    goto(r + 40);

    // Flush while waiting for tRCD; ACT in the flush cycle is dropped
    n = cyc + 1;
    for (int k = 0; k < 3; k++) act(READ, 1, 0, 1'b0);
    flush     = 1'b1;
    act_valid = 1'b1;
    act_bank  = 4'd2;
    step();
    flush     = 1'b0;
    act_valid = 1'b0;
    @(negedge clk);
    check("flush_q_count", q_count, 0);
    check("flush_idle", cas_idle, 1);
    check("flush_no_cas", cas_valid, 0);
    goto(n + 16);

    // Flush on the handshake cycle: that WRITE retires, the next is dropped
    n = cyc + 1;
    act(WRITE, 11, n + 4, 1'b1);
    act(WRITE, 12, 0, 1'b0);
    goto(n + 4);
    flush = 1'b1;
    step();
    flush = 1'b0;
    @(negedge clk);
    check("flush_hs_q_count", q_count, 0);
    check("flush_hs_idle", cas_idle, 1);
    step();
    // The retired WRITE must still govern the following READ
    n = cyc + 1;
    act(READ, 13, n + 12, 1'b1);
    goto(n + 2);
    rw_done = 1'b1;
    step();
    rw_done = 1'b0;
    goto(n + 20);

    // Reset while a CAS is pending drops it without a handshake
    cas_ready = 1'b0;
    n = cyc + 1;
    act(READ, 14, 0, 1'b0);
    goto_neg(n + 6);
    check("pre_reset_cas_valid", cas_valid, 1);
    step();
    rst = 1'b1;
    goto_neg(n + 8);
    check("mid_reset_cas_valid", cas_valid, 0);
    check("mid_reset_q_count", q_count, 0);
    check("mid_reset_idle", cas_idle, 1);
    check("mid_reset_act_ready", act_ready, 1);
    step();
    rst       = 1'b0;
    cas_ready = 1'b1;
    repeat (5) step();

    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
